temporal_spike_encoder: RTL and testbench

Converts binary-coded values into race-logic temporal spikes for downstream temporal operators such as the greater-than-or-equal comparator and other edge/pulse-coded primitives. One gamma cycle spans GAMMA_CYCLE_WIDTH clock cycles. A value v becomes a pulse whose rising edge lands v cycles into the gamma cycle. The block also drives the per-gamma-cycle reset pulse that clears the SR latches in consumer operators. It sits at the binary-to-temporal boundary and accepts one vector of NUM_CH values per gamma cycle over a valid/ready handshake.

---
 rtl/temporal_spike_encoder_if.sv | 24 ++
 rtl/temporal_spike_encoder.sv | 100 ++++++++++
 tb/tb_temporal_spike_encoder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/temporal_spike_encoder_if.sv
// Handshake and spike bundle between a binary producer, the temporal spike
// encoder and its race-logic consumers.
interface temporal_spike_encoder_if #(
    parameter int NUM_CH = 2,
    parameter int VAL_W  = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CH*VAL_W-1:0] in_vals;
    logic                    gamma_rst;
    logic [NUM_CH-1:0]       spike_out;
    logic [VAL_W-2:0]        gamma_t;
    logic                    busy;

    modport master (
        output in_valid, in_vals,
        input  in_ready, gamma_rst, spike_out, gamma_t, busy
    );

    modport slave (
        input  in_valid, in_vals,
        output in_ready, gamma_rst, spike_out, gamma_t, busy
    );
endinterface

// File: rtl/temporal_spike_encoder.sv
// Binary-to-race-logic encoder: each accepted lane value v becomes a pulse
// rising v steps into a gamma cycle, framed by an ARM cycle that pulses gamma_rst.
module temporal_spike_encoder #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_CH            = 2,
    parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic                     aclk,
    input  logic                     grst,
    temporal_spike_encoder_if.slave  bus
);

    localparam int T_W = VAL_W - 1;
    // Clamping the pulse to the gamma length keeps v+P inside VAL_W+1 bits; the
    // visible result is unchanged because pulses are cut at the last step anyway.
    localparam int P_EFF = (PULSE_WIDTH > GAMMA_CYCLE_WIDTH) ? GAMMA_CYCLE_WIDTH : PULSE_WIDTH;

    localparam logic [T_W-1:0] T_LAST = T_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [VAL_W:0] G_EXT  = (VAL_W + 1)'(GAMMA_CYCLE_WIDTH);
    localparam logic [VAL_W:0] P_EXT  = (VAL_W + 1)'(P_EFF);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_e;

    state_e                  state_q, state_d;
    logic [T_W-1:0]          t_q, t_d;
    logic [NUM_CH*VAL_W-1:0] vals_q, vals_d;
    logic [NUM_CH-1:0]       spike_q, spike_d;

    logic           lastStep;
    logic           ready;
    logic           accept;
    logic [VAL_W:0] laneVal;
    logic [VAL_W:0] tExt;

    always_comb begin
        lastStep = (state_q == RUN) && (t_q == T_LAST);
        ready    = !grst && ((state_q == IDLE) || lastStep);
        accept   = bus.in_valid && ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = ARM;
            ARM:  state_d = RUN;
            RUN: begin
                if (lastStep) state_d = accept ? ARM : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Spikes are computed from the upcoming state and step so the registered
    // output lines up with gamma_t in the same cycle.
    always_comb begin
        t_d     = '0;
        vals_d  = vals_q;
        spike_d = '0;
        laneVal = '0;
        tExt    = '0;

        if ((state_q == RUN) && (state_d == RUN)) t_d = t_q + 1'b1;
        if (accept) vals_d = bus.in_vals;

        tExt = {2'b00, t_d};
        for (int i = 0; i < NUM_CH; i++) begin
            laneVal    = {1'b0, vals_q[i*VAL_W +: VAL_W]};
            spike_d[i] = (state_d == RUN) && (laneVal < G_EXT)
                         && (tExt >= laneVal) && (tExt < laneVal + P_EXT);
        end
    end

    always_ff @(posedge aclk) begin
        if (grst) begin
            state_q <= IDLE;
            t_q     <= '0;
            vals_q  <= '0;
            spike_q <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            vals_q  <= vals_d;
            spike_q <= spike_d;
        end
    end

    always_comb begin
        bus.in_ready  = ready;
        bus.gamma_rst = (state_q == ARM);
        bus.busy      = (state_q != IDLE);
        bus.gamma_t   = t_q;
        bus.spike_out = spike_q;
    end

endmodule

// File: tb/tb_temporal_spike_encoder.sv
// Self-checking bench for temporal_spike_encoder: directed scenarios plus random
// traffic checked cycle by cycle against a timeline model of the gamma cycle.
module tb_temporal_spike_encoder;

    localparam int G      = 16;
    localparam int P      = 8;
    localparam int NUM_CH = 2;
    localparam int VAL_W  = $clog2(G) + 1;
    localparam int VEC_W  = NUM_CH * VAL_W;

    logic aclk = 1'b0;
    logic grst = 1'b1;

    always #5 aclk = ~aclk;

    temporal_spike_encoder_if #(.NUM_CH(NUM_CH), .VAL_W(VAL_W)) bus ();

    temporal_spike_encoder #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH(P),
        .NUM_CH(NUM_CH),
        .VAL_W(VAL_W)
    ) dut (
        .aclk(aclk),
        .grst(grst),
        .bus(bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: sinceAcc is the number of edges since the last acceptance (0 = idle).
    int               sinceAcc = 0;
    logic [VEC_W-1:0] stored   = '0;
    int               cycle    = 0;
    int               lastGr   = -1;
    int               prevGr   = -1;

    // Behavioural race-logic GE consumer: high when lane 0 arrives no earlier than lane 1.
    logic seenA = 1'b0;
    logic seenB = 1'b0;
    logic geQ   = 1'b0;

    always @(posedge aclk) begin
        if (bus.gamma_rst) begin
            seenA <= 1'b0;
            seenB <= 1'b0;
            geQ   <= 1'b0;
        end else begin
            if (bus.spike_out[1]) seenB <= 1'b1;
            if (bus.spike_out[0] && !seenA) begin
                seenA <= 1'b1;
                geQ   <= seenB || bus.spike_out[1];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
        end
    endtask

    function automatic logic [VEC_W-1:0] pack(input int a, input int b);
        logic [VEC_W-1:0] r;
        r = '0;
        r[0 +: VAL_W]     = VAL_W'(a);
        r[VAL_W +: VAL_W] = VAL_W'(b);
        return r;
    endfunction

    function automatic logic [NUM_CH-1:0] modelSpikes(input int t, input logic [VEC_W-1:0] vec);
        logic [NUM_CH-1:0] s;
        int v;
        int hi;
        s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            v  = int'(vec[i*VAL_W +: VAL_W]);
            hi = (v + P - 1 < G - 1) ? v + P - 1 : G - 1;
            s[i] = (v < G) && (t >= v) && (t <= hi);
        end
        return s;
    endfunction

    task automatic applyStimulus(input logic v, input logic [VEC_W-1:0] d, input logic r);
        logic              expRun;
        int                expT;
        logic              expReady;
        logic [NUM_CH-1:0] expSpk;

        @(negedge aclk);
        bus.in_valid = v;
        bus.in_vals  = d;
        grst         = r;
        #1;

        expRun   = (sinceAcc >= 2);
        expT     = expRun ? sinceAcc - 2 : 0;
        expReady = !r && ((sinceAcc == 0) || (sinceAcc == G + 1));
        expSpk   = expRun ? modelSpikes(expT, stored) : '0;

        checkOutput("in_ready",  32'(bus.in_ready),  32'(expReady));
        checkOutput("gamma_rst", 32'(bus.gamma_rst), 32'(sinceAcc == 1));
        checkOutput("busy",      32'(bus.busy),      32'(sinceAcc != 0));
        checkOutput("gamma_t",   32'(bus.gamma_t),   32'(expT));
        checkOutput("spike_out", 32'(bus.spike_out), 32'(expSpk));

        if (bus.gamma_rst === 1'b1) begin
            prevGr = lastGr;
            lastGr = cycle;
        end
        cycle++;

        @(posedge aclk);
        if (r) begin
            sinceAcc = 0;
        end else if (expReady && v) begin
            stored   = d;
            sinceAcc = 1;
        end else if (sinceAcc > 0) begin
            sinceAcc++;
            if (sinceAcc > G + 1) sinceAcc = 0;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_vals  = '0;
        grst         = 1'b1;
        repeat (2) @(posedge aclk);

        applyStimulus(1'b0, '0, 1'b1);
        idleCycles(2);

        // Single vector {v0=3, v1=0}
        applyStimulus(1'b1, pack(3, 0), 1'b0);
        idleCycles(G + 4);

        // Clipping and infinity {v0=15, v1=16}
        applyStimulus(1'b1, pack(15, 16), 1'b0);
        idleCycles(G + 4);

        // Back-to-back {2,5} then {7,1}
        lastGr = -1;
        prevGr = -1;
        applyStimulus(1'b1, pack(2, 5), 1'b0);
        for (int i = 0; i < G + 1; i++) applyStimulus(1'b1, pack(7, 1), 1'b0);
        idleCycles(G + 4);
        checkOutput("b2bPeriod", 32'(lastGr - prevGr), 32'(G + 1));

        // Backpressure with a producer that changes data while waiting
        applyStimulus(1'b1, pack(5, 5), 1'b0);
        idleCycles(5);
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1, pack($urandom_range(0, G - 1), $urandom_range(0, G - 1)), 1'b0);
        idleCycles(G + 4);

        // Reset mid-RUN at t=6 while lane 0 is high, with a vector offered in that cycle
        applyStimulus(1'b1, pack(3, 12), 1'b0);
        idleCycles(7);
        applyStimulus(1'b1, pack(1, 1), 1'b1);
        idleCycles(G + 2);

        // Downstream GE consumer
        applyStimulus(1'b1, pack(4, 9), 1'b0);
        idleCycles(G + 3);
        checkOutput("geA4B9", 32'(geQ), 32'(4 >= 9));
        applyStimulus(1'b1, pack(9, 4), 1'b0);
        idleCycles(G + 3);
        checkOutput("geA9B4", 32'(geQ), 32'(9 >= 4));

        // Random traffic including occasional resets and out-of-range values
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          pack($urandom_range(0, 2 * G - 1), $urandom_range(0, 2 * G - 1)),
                          ($urandom_range(0, 59) == 0));
        end
        idleCycles(G + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
